// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first, BIT_CYC clocks per bit,
// repeated a captured number of times with an optional idle gap between repetitions.
module seq_pattern_gen #(
    parameter int PAT_W   = 4,
    parameter int BIT_CYC = 2,
    parameter int GAP_CYC = 0,
    parameter int CNT_W   = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [CNT_W-1:0] i_repeat,
    output logic             o_bit,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int BCW   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int GCW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PAT_W - 1);
    localparam logic [BCW-1:0]   BIT_LAST = BCW'(BIT_CYC - 1);
    localparam logic [GCW-1:0]   GAP_LAST = GCW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state,   w_state;
    logic [PAT_W-1:0] r_pattern, w_pattern;
    logic [CNT_W-1:0] r_remain,  w_remain;
    logic [IDX_W-1:0] r_bitIdx,  w_bitIdx;
    logic [BCW-1:0]   r_bitCnt,  w_bitCnt;
    logic [GCW-1:0]   r_gapCnt,  w_gapCnt;

    always_comb begin
        w_state   = r_state;
        w_pattern = r_pattern;
        w_remain  = r_remain;
        w_bitIdx  = r_bitIdx;
        w_bitCnt  = r_bitCnt;
        w_gapCnt  = r_gapCnt;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_repeat != '0) begin
                        w_state   = S_SHIFT;
                        w_pattern = i_pattern;
                        w_remain  = i_repeat;
                        w_bitIdx  = IDX_MSB;
                        w_bitCnt  = '0;
                    end else begin
                        w_state = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (i_abort) begin
                    w_state = S_IDLE;
                end else if (r_bitCnt != BIT_LAST) begin
                    w_bitCnt = r_bitCnt + BCW'(1);
                end else begin
                    w_bitCnt = '0;
                    if (r_bitIdx != '0) begin
                        w_bitIdx = r_bitIdx - IDX_W'(1);
                    end else begin
                        // End of one repetition: restart at the MSB unless this was the last one
                        w_bitIdx = IDX_MSB;
                        w_remain = r_remain - CNT_W'(1);
                        if (r_remain == CNT_W'(1)) begin
                            w_state = S_DONE;
                        end else if (GAP_CYC > 0) begin
                            w_state  = S_GAP;
                            w_gapCnt = '0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (i_abort) begin
                    w_state = S_IDLE;
                end else if (r_gapCnt == GAP_LAST) begin
                    w_state  = S_SHIFT;
                    w_gapCnt = '0;
                end else begin
                    w_gapCnt = r_gapCnt + GCW'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
        // Returning to IDLE (normal end or abort) always leaves the datapath cleared
        if (w_state == S_IDLE) begin
            w_pattern = '0;
            w_remain  = '0;
            w_bitIdx  = '0;
            w_bitCnt  = '0;
            w_gapCnt  = '0;
        end
    end

    // Outputs are registered from the next-state values so they line up with the state register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_remain  <= '0;
            r_bitIdx  <= '0;
            r_bitCnt  <= '0;
            r_gapCnt  <= '0;
            o_bit     <= 1'b0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_pattern <= w_pattern;
            r_remain  <= w_remain;
            r_bitIdx  <= w_bitIdx;
            r_bitCnt  <= w_bitCnt;
            r_gapCnt  <= w_gapCnt;
            o_bit     <= (w_state == S_SHIFT) && w_pattern[w_bitIdx];
            o_valid   <= (w_state == S_SHIFT);
            o_busy    <= (w_state == S_SHIFT) || (w_state == S_GAP);
            o_done    <= (w_state == S_DONE);
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: one instance without gap (BIT_CYC=2), one with a gap (BIT_CYC=1, GAP_CYC=3).
// Cycle k is observed on the falling edge just before the k-th rising edge after the start-sampling edge.
module tb_seq_pattern_gen;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       startA;
    logic       startB;
    logic       abort;
    logic [3:0] pattern;
    logic [7:0] repeatCnt;

    logic bitA, validA, busyA, doneA;
    logic bitB, validB, busyB, doneB;

    int testsRun    = 0;
    int testsFailed = 0;

    // Expected {bit, valid, busy, done} for the gap instance, cycles 1..12
    logic [3:0] expB [12] = '{4'b1110, 4'b0110, 4'b0110, 4'b1110,
                              4'b0010, 4'b0010, 4'b0010,
                              4'b1110, 4'b0110, 4'b0110, 4'b1110,
                              4'b0001};

    seq_pattern_gen #(.PAT_W(4), .BIT_CYC(2), .GAP_CYC(0), .CNT_W(8)) dutA (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_start   (startA),
        .i_abort   (abort),
        .i_pattern (pattern),
        .i_repeat  (repeatCnt),
        .o_bit     (bitA),
        .o_valid   (validA),
        .o_busy    (busyA),
        .o_done    (doneA)
    );

    seq_pattern_gen #(.PAT_W(4), .BIT_CYC(1), .GAP_CYC(3), .CNT_W(8)) dutB (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_start   (startB),
        .i_abort   (abort),
        .i_pattern (pattern),
        .i_repeat  (repeatCnt),
        .o_bit     (bitB),
        .o_valid   (validB),
        .o_busy    (busyB),
        .o_done    (doneB)
    );

    task automatic nextCycle();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic rs,
                                 input logic [3:0] pat, input logic [7:0] rep);
        startA    = st;
        abort     = ab;
        reset     = rs;
        pattern   = pat;
        repeatCnt = rep;
    endtask

    task automatic checkOutput(input string tag, input int cyc, input logic [3:0] obs, input logic [3:0] expVal);
        testsRun++;
        assert (obs === expVal) else begin
            testsFailed++;
            $error("[TB] FAIL %s cycle %0d: bit/valid/busy/done observed %b expected %b", tag, cyc, obs, expVal);
        end
    endtask

    // Starts dutA and checks cycles 1..len+1; intrude/abortAt/resetAt (0 = none) inject events at that cycle's edge.
    // Returns positioned in cycle len+1 with the inputs for that edge not yet driven.
    task automatic runA(input string tag, input logic [3:0] pat, input logic [7:0] rep,
                        input logic [31:0] expStr, input int len,
                        input int intrude, input int abortAt, input int resetAt);
        logic [3:0] expVal;
        int stopAt;
        stopAt = (abortAt != 0) ? abortAt : resetAt;
        applyStimulus(1'b1, 1'b0, 1'b0, pat, rep);
        nextCycle();
        for (int k = 1; k <= len + 1; k++) begin
            if (stopAt != 0 && k > stopAt)
                expVal = 4'b0000;
            else if (k == len + 1)
                expVal = 4'b0001;
            else
                expVal = {expStr[len - k], 3'b110};
            checkOutput(tag, k, {bitA, validA, busyA, doneA}, expVal);
            if (k <= len) begin
                applyStimulus(k == intrude, k == abortAt, k == resetAt, 4'b0000, 8'd1);
                nextCycle();
            end
        end
    endtask

    initial begin
        startB = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0);
        nextCycle();
        nextCycle();
        checkOutput("resetA", 0, {bitA, validA, busyA, doneA}, 4'b0000);
        checkOutput("resetB", 0, {bitB, validB, busyB, doneB}, 4'b0000);
        reset = 1'b0;
        nextCycle();

        // T1: 1010 x3, each bit held two clocks
        runA("T1", 4'b1010, 8'd3, 32'h00CCCCCC, 24, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0);
        nextCycle();
        checkOutput("T1idle", 26, {bitA, validA, busyA, doneA}, 4'b0000);

        // T3: zero repeat count goes straight to a done pulse
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1111, 8'd0);
        nextCycle();
        checkOutput("T3done", 1, {bitA, validA, busyA, doneA}, 4'b0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0);
        nextCycle();
        checkOutput("T3idle", 2, {bitA, validA, busyA, doneA}, 4'b0000);

        // T4: start while busy ignored, start in done cycle ignored, start on the next cycle accepted
        runA("T4", 4'b1010, 8'd3, 32'h00CCCCCC, 24, 5, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1100, 8'd1);
        nextCycle();
        checkOutput("T4ignored", 26, {bitA, validA, busyA, doneA}, 4'b0000);
        nextCycle();
        checkOutput("T4accept", 27, {bitA, validA, busyA, doneA}, 4'b1110);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0011, 8'd0);
        for (int c = 28; c <= 35; c++) begin
            nextCycle();
            checkOutput("T4restart", c, {bitA, validA, busyA, doneA},
                        (c == 35) ? 4'b0001 : (c <= 30 ? 4'b1110 : 4'b0110));
        end
        nextCycle();

        // T5: abort mid-transfer, then a clean fresh start
        runA("T5", 4'b1010, 8'd3, 32'h00CCCCCC, 24, 0, 10, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0);
        nextCycle();
        runA("T5fresh", 4'b1010, 8'd1, 32'h000000CC, 8, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0);
        nextCycle();

        // T6: synchronous reset mid-transfer, then a single 1100 repetition
        runA("T6", 4'b1010, 8'd3, 32'h00CCCCCC, 24, 0, 0, 7);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0);
        nextCycle();
        runA("T6fresh", 4'b1100, 8'd1, 32'h000000F0, 8, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0);
        nextCycle();

        // T2: 1001 x2 with a three-clock gap on the second instance
        pattern   = 4'b1001;
        repeatCnt = 8'd2;
        startB    = 1'b1;
        nextCycle();
        startB    = 1'b0;
        pattern   = 4'b0110;
        repeatCnt = 8'd7;
        for (int c = 1; c <= 12; c++) begin
            checkOutput("T2", c, {bitB, validB, busyB, doneB}, expB[c-1]);
            nextCycle();
        end
        checkOutput("T2idle", 13, {bitB, validB, busyB, doneB}, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial bit-pattern transmitter, the source side of the sequence-detector path. It loads a PAT_W-bit pattern and sends it MSB-first on a single-bit output, holding each bit for BIT_CYC clocks. The pattern is repeated a programmable number of times with an optional idle gap between repetitions. It drives detector inputs (e.g. a 1010 Moore detector's button input) in-system and in benches.

Parameters:
PAT_W, 4, pattern width in bits (>=1)
BIT_CYC, 2, clocks each bit is held on o_bit (>=1)
GAP_CYC, 0, idle clocks between repetitions (0 = back-to-back)
CNT_W, 8, width of repeat count

Ports:
i_clock  input  1  system clock, all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_start  input  1  start request, sampled only in IDLE
i_abort  input  1  terminate transfer, no done pulse
i_pattern  input  PAT_W  pattern, captured when start is accepted
i_repeat  input  CNT_W  number of repetitions, captured with the pattern
o_bit  output  1  serial data, MSB first; 0 whenever o_valid=0
o_valid  output  1  high while a pattern bit is driven
o_busy  output  1  high from the cycle after start acceptance until done/abort
o_done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- Clock and reset: one clock i_clock; i_reset synchronous, active-high. On a reset edge: state=IDLE, all outputs 0, internal counters and registers 0. Reset wins over every other input, including mid-transfer.
- All outputs are registered. "Cycle k" means the k-th rising edge after the edge that samples i_start=1 in IDLE.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - On i_start=1 and i_repeat!=0: capture i_pattern and i_repeat, go to SHIFT.
  - On i_start=1 and i_repeat==0: go to DONE. o_done pulses at cycle 1, o_busy stays 0, no bits are sent.
- SHIFT:
  - o_valid=1, o_bit=current pattern bit. The first bit (MSB) is driven from cycle 1.
  - A bit-cycle counter runs 0..BIT_CYC-1. On wrap, advance to the next bit (bit index PAT_W-1 down to 0).
  - After bit 0 finishes, decrement the remaining count.
    - Count still nonzero and GAP_CYC>0: go to GAP.
    - Count still nonzero and GAP_CYC==0: restart at the MSB on the very next cycle, with no bubble.
    - Count reaches 0: go to DONE.
- GAP: o_valid=0, o_bit=0, o_busy=1 for exactly GAP_CYC cycles, then SHIFT at the MSB.
- DONE: lasts one cycle. o_done=1, o_busy=0, o_valid=0. Next state is IDLE. i_start is ignored in DONE.
- Transfer length: the last valid bit is at cycle R*(PAT_W*BIT_CYC) + (R-1)*GAP_CYC, where R is the captured repeat count. o_done pulses on the following cycle.
- Minimum restart: i_start is accepted no earlier than the cycle after the o_done pulse.
- i_start while busy: ignored. The captured pattern and count are not disturbed.
- Pattern stability: changes on i_pattern or i_repeat after capture have no effect.
- i_abort=1 in SHIFT or GAP: next edge goes to IDLE, all outputs 0, no o_done. i_abort in IDLE or DONE has no effect.
- Simultaneous i_abort and the final bit edge: abort wins, no o_done.
- Count arithmetic: the repeat counter is unsigned CNT_W bits, so the maximum is 2^CNT_W-1 repetitions.

Test Plan:
- T1: PAT_W=4, BIT_CYC=2, GAP_CYC=0, pattern=4'b1010, repeat=3 -> o_bit over cycles 1..24 = 11001100 repeated 3x, o_valid=1 on cycles 1..24, o_done=1 only at cycle 25, o_busy=0 at cycle 25. A seq_1010 detector fed by o_bit asserts o_led on each 1010 completion (detector assertion count checked against its overlap mode).
- T2: GAP_CYC=3, pattern=4'b1001, repeat=2, BIT_CYC=1 -> 1001 on cycles 1-4, o_valid=0 and o_bit=0 on cycles 5-7, 1001 on cycles 8-11, o_done at cycle 12.
- T3: repeat=0 with i_start=1 -> o_done at cycle 1, o_valid and o_busy never assert.
- T4: i_start pulsed again at cycle 5 with pattern=4'b0000 during T1 -> output stream identical to T1. Then i_start in the o_done cycle -> ignored. i_start on the next cycle -> accepted.
- T5: i_abort at cycle 10 of T1 -> at cycle 11 o_busy=0, o_valid=0, o_bit=0, and no o_done ever follows. A fresh start afterwards begins cleanly at the MSB.
- T6: i_reset=1 at cycle 7 of T1 -> next edge all outputs 0, state IDLE. After reset release, i_start with pattern=4'b1100, repeat=1 -> 11110000 (BIT_CYC=2), o_done at cycle 9.
